beam_sequencer: RTL
===================

Name: beam_sequencer

Overview:
- Parametrised successor of the scanner's control path: the control FIFO, duration counter and comparator become a single programmable sequence engine.
- Holds a table of DEPTH entries. Each entry is {ch, ctrl, cnt}. It plays them in order, holding each entry's control bits for cnt+1 clocks.
- Supports multi-channel beam select, frame wrap (retransmit), halt on data read-out, and error flags.
- Drives the burst/ADC/sample enables of the clock generator and the channel mux; sits between the SPI register bus and CLK_gen.

Parameters:
- CNT_W, 16, duration field width.
- CTRL_W, 8, control field width (minimum 5).
- DEPTH, 16, table entries (power of 2, minimum 2).
- NCH, 4, beam channels; CH_W = max(1, $clog2(NCH)).

Ports:
- CLK_64MHz  in  1  system clock.
- nRESET  in  1  synchronous active-low reset.
- nENABLE  in  1  active-low run request.
- tbl_wr  in  1  write strobe, one entry per cycle high.
- tbl_wdata  in  CH_W+CTRL_W+CNT_W  entry {ch, ctrl, cnt}.
- tbl_clr  in  1  empties the table and clears sticky errors.
- hold_req  in  1  data read-out active (RD_DATA).
- burst_en  out  1  ctrl[1] while running.
- adc_en  out  1  ctrl[2] while running.
- smpl_en  out  1  ctrl[3] while running.
- ctrl_out  out  CTRL_W  raw ctrl of the current entry.
- ch_sel  out  CH_W  channel of the current entry.
- entry_idx  out  $clog2(DEPTH)  current entry index.
- tbl_count  out  $clog2(DEPTH)+1  number of entries loaded.
- busy  out  1  high in RUN or HOLD.
- frame_done  out  1  one-cycle pulse on wrap.
- err_full  out  1  sticky: write attempted when table full.
- err_busy  out  1  sticky: write attempted while busy.
- err_empty  out  1  sticky: run requested with empty table.

Behaviour:
- Ctrl bit map: [0] RETRANS, [1] BURST, [2] ADC_ON, [3] SAMPLE_ON, [4] HALT, [CTRL_W-1:5] passed through on ctrl_out only.
- Reset (nRESET low at a clock edge):
  - State = IDLE; all outputs 0; tbl_count = 0.
  - Table contents are don't-care.
- Table:
  - Register array with asynchronous read, so entry change has zero bubble.
  - tbl_wr in IDLE with tbl_count < DEPTH: writes entry[tbl_count], then tbl_count+1.
  - tbl_wr when full: dropped, err_full set.
  - tbl_wr in RUN/HOLD: dropped, err_busy set.
  - tbl_clr: tbl_count = 0 and all err_* cleared. Accepted only in IDLE; ignored otherwise.
  - tbl_clr and tbl_wr in the same cycle: clr wins.
- States: IDLE, RUN, HOLD, DONE.
- IDLE:
  - Outputs 0, entry_idx 0, duration counter 0.
  - nENABLE low and tbl_count > 0: go to RUN next cycle; entry 0 is visible in that first RUN cycle.
  - nENABLE low and tbl_count == 0: set err_empty and stay in IDLE.
- RUN:
  - Outputs reflect entry[entry_idx]: burst_en = ctrl[1], adc_en = ctrl[2], smpl_en = ctrl[3]; ctrl_out and ch_sel follow the entry.
  - The counter increments each cycle.
  - When counter == cnt, the entry ends:
    - If RETRANS is set: entry_idx = 0, frame_done pulses in the same cycle as the wrap edge.
    - Else if entry_idx == tbl_count-1: go to DONE.
    - Else: entry_idx+1.
    - In every case the counter resets to 0.
  - Each entry lasts exactly cnt+1 cycles. cnt = 0 gives 1 cycle.
- HOLD:
  - Entered from RUN when ctrl[4] & hold_req.
  - Counter frozen; outputs held.
  - Returns to RUN the cycle after hold_req falls.
  - Entry termination is never evaluated while in HOLD.
- DONE: outputs 0, busy 0; returns to IDLE when nENABLE goes high.
- nENABLE high in RUN or HOLD: IDLE next cycle, with outputs, counter and entry_idx all 0. Table retained.
- Counter width is CNT_W. It cannot overflow, because it resets at compare.

Optional Feature:
- Macro: BEAM_SEQ_LOOP_LIMIT_EN.
- When defined:
  - Adds input loop_max [15:0] and output loop_cnt [15:0].
  - loop_cnt increments on each frame_done.
  - When a wrap makes loop_cnt == loop_max (loop_max != 0), the FSM enters DONE instead of wrapping.
  - loop_max = 0 means loop forever.
  - loop_cnt clears in IDLE.
- When undefined: RETRANS always wraps forever; neither port exists.

Decomposition:
- Package beam_seq_pkg:
  - State enum.
  - Ctrl bit index constants (RETRANS_B = 0, BURST_B = 1, ADC_B = 2, SMPL_B = 3, HALT_B = 4).
  - Entry field offset functions of the parameters.
- Sub-module beam_seq_table: register array, write pointer/count, full flag, async read port.
- FSM and counter stay in beam_sequencer.

Test Plan:
- Duration: load 3 entries, cnt = {2, 0, 5}, no RETRANS, nENABLE low → adc/burst pattern lasts 3, 1, 6 cycles, then DONE with outputs 0.
- Wrap: entries {cnt=1}, {cnt=1, RETRANS} → period 4 cycles, frame_done every 4th cycle, entry_idx 0,0,1,1,0…
- Halt: entry cnt = 3 with HALT; hold_req high for 5 cycles mid-entry → entry lasts 9 cycles, outputs steady throughout.
- Abort: nENABLE high during entry 1 → next cycle outputs 0, entry_idx 0; re-enable restarts at entry 0 with the full count.
- Errors: DEPTH+1 writes → err_full = 1, tbl_count = DEPTH; write while busy → err_busy; run with empty table → err_empty; tbl_clr clears all three.
- BEAM_SEQ_LOOP_LIMIT_EN, loop_max = 3 → exactly 3 frame_done pulses, then DONE; reset mid-run → all outputs 0 on the next edge.

Source files
------------

// File: rtl/beam_seq_pkg.sv
// Shared state codes, ctrl bit indices and entry field helpers for the beam sequencer.
package beam_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_HOLD = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  localparam int unsigned RETRANS_B = 0;
  localparam int unsigned BURST_B   = 1;
  localparam int unsigned ADC_B     = 2;
  localparam int unsigned SMPL_B    = 3;
  localparam int unsigned HALT_B    = 4;

  function automatic int unsigned ch_width(input int unsigned nch);
    return (nch > 1) ? 32'($clog2(nch)) : 32'd1;
  endfunction

  // Entry layout is {ch, ctrl, cnt} with cnt in the LSBs.
  function automatic int unsigned ctrl_lsb(input int unsigned cnt_w);
    return cnt_w;
  endfunction

  function automatic int unsigned ch_lsb(input int unsigned cnt_w, input int unsigned ctrl_w);
    return cnt_w + ctrl_w;
  endfunction

  function automatic int unsigned entry_width(input int unsigned cnt_w, input int unsigned ctrl_w,
                                              input int unsigned ch_w);
    return cnt_w + ctrl_w + ch_w;
  endfunction

endpackage

// File: rtl/beam_seq_table.sv
// Sequence table: register array filled in order, with a fill count and an asynchronous read port.
module beam_seq_table #(
  parameter int unsigned ENT_W = 26,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned IDX_W    = $clog2(DEPTH),
  localparam int unsigned CNT_BITS = IDX_W + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr,
  input  logic                clr,
  input  logic [ENT_W-1:0]    wdata,
  input  logic [IDX_W-1:0]    raddr,
  output logic [ENT_W-1:0]    rdata,
  output logic [CNT_BITS-1:0] count,
  output logic                full
);

  logic [ENT_W-1:0] mem [DEPTH];
  logic             wr_ok;

  assign full  = (count == CNT_BITS'(DEPTH));
  assign wr_ok = wr & ~clr & ~full;
  assign rdata = mem[raddr];

  // Contents need no reset; only the fill count defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[count[IDX_W-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_ok) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/beam_sequencer.sv
// Programmable beam sequence engine: plays {ch, ctrl, cnt} entries, each held for cnt+1 clocks.
// Optional frame loop limit (loop_max / loop_cnt) enabled by `define BEAM_SEQ_LOOP_LIMIT_EN.
module beam_sequencer
  import beam_seq_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned NCH    = 4,
  localparam int unsigned CH_W  = ch_width(NCH),
  localparam int unsigned IDX_W = $clog2(DEPTH),
  localparam int unsigned ENT_W = entry_width(CNT_W, CTRL_W, CH_W)
) (
  input  logic              CLK_64MHz,
  input  logic              nRESET,
  input  logic              nENABLE,
  input  logic              tbl_wr,
  input  logic [ENT_W-1:0]  tbl_wdata,
  input  logic              tbl_clr,
  input  logic              hold_req,
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
  input  logic [15:0]       loop_max,
  output logic [15:0]       loop_cnt,
`endif
  output logic              burst_en,
  output logic              adc_en,
  output logic              smpl_en,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [CH_W-1:0]   ch_sel,
  output logic [IDX_W-1:0]  entry_idx,
  output logic [IDX_W:0]    tbl_count,
  output logic              busy,
  output logic              frame_done,
  output logic              err_full,
  output logic              err_busy,
  output logic              err_empty
);

  localparam int unsigned CTRL_LSB = ctrl_lsb(CNT_W);
  localparam int unsigned CH_LSB   = ch_lsb(CNT_W, CTRL_W);
  localparam int unsigned CNT_BITS = IDX_W + 1;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx_nxt;
  logic [CNT_W-1:0]  ctr, ctr_nxt, cur_cnt;
  logic              frame_nxt, set_empty, run_nxt;
  logic              idle, active, clr_ok, wr_ok, last_entry, tbl_full;
  logic [ENT_W-1:0]  rd_data;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [CH_W-1:0]   rd_ch;
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
  logic [15:0]       loop_nxt;
`endif

  assign idle       = (state == ST_IDLE);
  assign active     = (state == ST_RUN) || (state == ST_HOLD);
  assign clr_ok     = tbl_clr & idle;
  assign wr_ok      = tbl_wr & idle & ~tbl_clr;
  assign last_entry = ((CNT_BITS'(entry_idx) + 1'b1) == tbl_count);

  // The table is read at the next index so outputs can be registered with no entry bubble.
  beam_seq_table #(
    .ENT_W (ENT_W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (CLK_64MHz),
    .rst_n (nRESET),
    .wr    (wr_ok),
    .clr   (clr_ok),
    .wdata (tbl_wdata),
    .raddr (idx_nxt),
    .rdata (rd_data),
    .count (tbl_count),
    .full  (tbl_full)
  );

  assign rd_cnt  = rd_data[CNT_W-1:0];
  assign rd_ctrl = rd_data[CTRL_LSB +: CTRL_W];
  assign rd_ch   = rd_data[CH_LSB +: CH_W];
  assign run_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);

  always_comb begin
    state_nxt = state;
    idx_nxt   = entry_idx;
    ctr_nxt   = ctr;
    frame_nxt = 1'b0;
    set_empty = 1'b0;
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
    loop_nxt  = loop_cnt;
`endif
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        ctr_nxt = '0;
        if (!nENABLE && !tbl_clr) begin
          if (tbl_count != '0) begin
            state_nxt = ST_RUN;
          end else begin
            set_empty = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (nENABLE) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          ctr_nxt   = '0;
        end else if (ctr == cur_cnt) begin
          ctr_nxt = '0;
          if (ctrl_out[RETRANS_B]) begin
            idx_nxt   = '0;
            frame_nxt = 1'b1;
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
            loop_nxt  = loop_cnt + 1'b1;
            if ((loop_max != '0) && (loop_nxt == loop_max)) begin
              state_nxt = ST_DONE;
            end
`endif
          end else if (last_entry) begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = entry_idx + 1'b1;
          end
        end else begin
          // Termination wins over a hold so every entry still gets exactly cnt+1 run cycles.
          ctr_nxt = ctr + 1'b1;
          if (ctrl_out[HALT_B] && hold_req) begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (nENABLE) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
          ctr_nxt   = '0;
        end else if (!hold_req) begin
          state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        idx_nxt = '0;
        ctr_nxt = '0;
        if (nENABLE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
        ctr_nxt   = '0;
      end
    endcase
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
    if (state_nxt == ST_IDLE) begin
      loop_nxt = '0;
    end
`endif
  end

  always_ff @(posedge CLK_64MHz) begin
    if (!nRESET) begin
      state      <= ST_IDLE;
      entry_idx  <= '0;
      ctr        <= '0;
      cur_cnt    <= '0;
      burst_en   <= 1'b0;
      adc_en     <= 1'b0;
      smpl_en    <= 1'b0;
      ctrl_out   <= '0;
      ch_sel     <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
      loop_cnt   <= '0;
`endif
    end else begin
      state      <= state_nxt;
      entry_idx  <= idx_nxt;
      ctr        <= ctr_nxt;
      cur_cnt    <= run_nxt ? rd_cnt : '0;
      burst_en   <= run_nxt & rd_ctrl[BURST_B];
      adc_en     <= run_nxt & rd_ctrl[ADC_B];
      smpl_en    <= run_nxt & rd_ctrl[SMPL_B];
      ctrl_out   <= run_nxt ? rd_ctrl : '0;
      ch_sel     <= run_nxt ? rd_ch : '0;
      busy       <= run_nxt;
      frame_done <= frame_nxt;
`ifdef BEAM_SEQ_LOOP_LIMIT_EN
      loop_cnt   <= loop_nxt;
`endif
    end
  end

  // Sticky error flags, cleared only by an accepted table clear.
  always_ff @(posedge CLK_64MHz) begin
    if (!nRESET) begin
      err_full  <= 1'b0;
      err_busy  <= 1'b0;
      err_empty <= 1'b0;
    end else if (clr_ok) begin
      err_full  <= 1'b0;
      err_busy  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      err_full  <= err_full | (tbl_wr & tbl_full);
      err_busy  <= err_busy | (tbl_wr & active);
      err_empty <= err_empty | set_empty;
    end
  end

endmodule
